// File: rtl/seq_mult4_pkg.sv
// seq_mult4 shared types and constants.
// Imported by the multiplier slice.
package seq_mult4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

  localparam int N_ITER = 4;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = $clog2(N_ITER);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(N_ITER - 1);

endpackage

// File: rtl/seq_mult4_if.sv
// Request/result bundle for seq_mult4.
// master drives operands, slave returns the product.
interface seq_mult4_if;
  import seq_mult4_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/adder4.sv
// 4-bit ripple-carry adder.
// Chains four full_adder cells.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[4];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
// Building block of adder4.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_mult4.sv
// Sequential 4x4 shift-and-add multiplier.
// One adder4 pass per RUN cycle, product on done.
module seq_mult4
  import seq_mult4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  seq_mult4_if.slave   bus
);

  mult_state_t state;
  mult_state_t state_n;

  logic [OP_W-1:0]   mcand;
  logic [OP_W-1:0]   acc_hi;
  logic [OP_W-1:0]   mq;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] prod_q;

  logic [OP_W-1:0]   addend;
  logic [OP_W-1:0]   sum;
  logic              cout;
  logic [OP_W-1:0]   acc_hi_n;
  logic [OP_W-1:0]   mq_n;
  logic              last;

  assign addend = mq[0] ? mcand : '0;

  adder4 u_add (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // {cout,sum,mq} shifted right by one
  assign acc_hi_n = {cout, sum[OP_W-1:1]};
  assign mq_n     = {sum[0], mq[OP_W-1:1]};
  assign last     = (cnt == CNT_LAST);

  always_comb begin
    state_n  = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_n = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      mq     <= '0;
      cnt    <= '0;
      prod_q <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.a;
            mq     <= bus.b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc_hi <= acc_hi_n;
          mq     <= mq_n;
          cnt    <= cnt + 1'b1;
          if (last) prod_q <= {acc_hi_n, mq_n};
        end
        default: ;
      endcase
    end
  end

  assign bus.product = prod_q;

endmodule
